// File: rtl/write_back_arbiter_pkg.sv
// Shared types for the write-back stage: datapath widths, register masks and
// the buffered long-latency result entry.
package write_back_arbiter_pkg;

    localparam int DATA_WIDTH        = 32;
    localparam int REG_FILE_SIZE     = 32;
    localparam int REG_NUM_WIDTH     = $clog2(REG_FILE_SIZE);
    localparam int BUF_DEPTH_DEFAULT = 2;

    typedef logic [DATA_WIDTH-1:0]    DataPath;
    typedef logic [REG_NUM_WIDTH-1:0] RegNumPath;
    typedef logic [REG_FILE_SIZE-1:0] RegMaskPath;

    typedef struct packed {
        RegNumPath num;
        DataPath   data;
    } wb_entry_t;

    function automatic RegMaskPath reg_bit(input RegNumPath n);
        reg_bit = RegMaskPath'(1) << n;
    endfunction

endpackage

// File: rtl/write_back_arbiter_if.sv
// Bundle of the ALU, long-latency, issue and register-file write signals.
// master = upstream/register-file side, slave = the write-back arbiter.
interface write_back_arbiter_if;
    import write_back_arbiter_pkg::*;

    logic       aluValid;
    RegNumPath  aluNum;
    DataPath    aluData;
    logic       lngValid;
    logic       lngReady;
    RegNumPath  lngNum;
    DataPath    lngData;
    logic       issueLng;
    RegNumPath  issueNum;
    RegMaskPath pendMask;
    logic       stallReq;
    DataPath    wrData;
    RegNumPath  wrNum;
    logic       regWrite;

    modport master (
        output aluValid, aluNum, aluData, lngValid, lngNum, lngData, issueLng, issueNum,
        input  lngReady, pendMask, stallReq, wrData, wrNum, regWrite
    );

    modport slave (
        input  aluValid, aluNum, aluData, lngValid, lngNum, lngData, issueLng, issueNum,
        output lngReady, pendMask, stallReq, wrData, wrNum, regWrite
    );
endinterface

// File: rtl/write_back_arbiter_wb_result_fifo.sv
// Circular holding buffer for long-latency results; pointers wrap modulo
// BUF_DEPTH so non-power-of-two depths work.
module wb_result_fifo
    import write_back_arbiter_pkg::*;
#(
    parameter int BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    wb_entry_t        mem_q [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        next_ptr = (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(BUF_DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = push_ok ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? next_ptr(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_entry;
        end
    end

endmodule

// File: rtl/write_back_arbiter.sv
// Merges ALU and buffered long-latency results onto the single register-file
// write port and tracks outstanding long-latency destinations.
module write_back_arbiter
    import write_back_arbiter_pkg::*;
#(
    parameter int BUF_DEPTH = BUF_DEPTH_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    write_back_arbiter_if.slave  bus
);

    logic       fifo_full;
    logic       fifo_empty;
    wb_entry_t  fifo_head;
    wb_entry_t  push_entry;
    logic       push;
    logic       pop;
    RegNumPath  sel_num;
    DataPath    sel_data;
    logic       regWrite_d, regWrite_q;
    RegNumPath  wrNum_d, wrNum_q;
    DataPath    wrData_d, wrData_q;
    RegMaskPath pend_d, pend_q;

    assign bus.lngReady = rst && !fifo_full;
    assign push         = bus.lngValid && bus.lngReady;
    assign push_entry   = '{num: bus.lngNum, data: bus.lngData};
    // The ALU cannot be back-pressured, so the buffer only drains on idle ALU cycles.
    assign pop          = !bus.aluValid && !fifo_empty;

    wb_result_fifo #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (fifo_head)
    );

    always_comb begin
        sel_num    = bus.aluValid ? bus.aluNum  : fifo_head.num;
        sel_data   = bus.aluValid ? bus.aluData : fifo_head.data;
        regWrite_d = (bus.aluValid || pop) && (sel_num != '0);
        wrNum_d    = regWrite_d ? sel_num  : wrNum_q;
        wrData_d   = regWrite_d ? sel_data : wrData_q;

        // Clear first so a same-edge re-issue of the same register keeps it pending.
        pend_d = pend_q;
        if (pop) begin
            pend_d = pend_d & ~reg_bit(fifo_head.num);
        end
        if (bus.issueLng && (bus.issueNum != '0)) begin
            pend_d = pend_d | reg_bit(bus.issueNum);
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            regWrite_q <= 1'b0;
            wrNum_q    <= '0;
            wrData_q   <= '0;
            pend_q     <= '0;
        end else begin
            regWrite_q <= regWrite_d;
            wrNum_q    <= wrNum_d;
            wrData_q   <= wrData_d;
            pend_q     <= pend_d;
        end
    end

    assign bus.regWrite = regWrite_q;
    assign bus.wrNum    = wrNum_q;
    assign bus.wrData   = wrData_q;
    assign bus.pendMask = pend_q;
    assign bus.stallReq = fifo_full;

endmodule

// File: tb/tb_write_back_arbiter.sv
// Self-checking bench: ALU vector table, hand-written long-latency sequences,
// and a scoreboard of expected register-file writes.
module tb_write_back_arbiter;
    import write_back_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    write_back_arbiter_if bus ();

    write_back_arbiter #(
        .BUF_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic      v;
        RegNumPath num;
        DataPath   data;
        logic      exp_we;
        RegNumPath exp_num;
        DataPath   exp_data;
    } alu_vec_t;

    typedef struct {
        RegNumPath num;
        DataPath   data;
    } wr_t;

    wr_t      sb_q[$];
    alu_vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input RegNumPath n, input DataPath d);
        wr_t w;
        w.num  = n;
        w.data = d;
        sb_q.push_back(w);
    endtask

    // Every register-file write must match the oldest expected write.
    always @(negedge clk) begin
        if (bus.aluValid === 1'b1 && bus.stallReq === 1'b1)
            $display("note protocol error: aluValid asserted while stallReq high");
        if (bus.regWrite === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_write: got r%0d=0x%0h expected no write",
                         bus.wrNum, bus.wrData);
            end else begin
                wr_t w;
                w = sb_q.pop_front();
                chk("sb_wrNum", 32'(bus.wrNum), 32'(w.num));
                chk("sb_wrData", bus.wrData, w.data);
            end
        end
    end

    initial begin
        bus.aluValid = 0; bus.aluNum = '0; bus.aluData = '0;
        bus.lngValid = 0; bus.lngNum = '0; bus.lngData = '0;
        bus.issueLng = 0; bus.issueNum = '0;

        vecs[0] = '{1'b1, 5'd3,  32'h55,       1'b1, 5'd3,  32'h55};
        vecs[1] = '{1'b1, 5'd0,  32'h77,       1'b0, 5'd3,  32'h55};
        vecs[2] = '{1'b0, 5'd7,  32'h99,       1'b0, 5'd3,  32'h55};
        vecs[3] = '{1'b1, 5'd31, 32'hDEADBEEF, 1'b1, 5'd31, 32'hDEADBEEF};
        vecs[4] = '{1'b1, 5'd1,  32'h1,        1'b1, 5'd1,  32'h1};
        vecs[5] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd1,  32'h1};

        // Reset state
        tick(); tick();
        chk("rst_regWrite", 32'(bus.regWrite), 32'd0);
        chk("rst_wrNum", 32'(bus.wrNum), 32'd0);
        chk("rst_wrData", bus.wrData, 32'd0);
        chk("rst_pendMask", bus.pendMask, 32'd0);
        chk("rst_lngReady", 32'(bus.lngReady), 32'd0);
        chk("rst_stallReq", 32'(bus.stallReq), 32'd0);
        rst = 1'b1;
        #1;
        chk("rel_lngReady", 32'(bus.lngReady), 32'd1);
        tick();

        // ALU vectors
        for (int i = 0; i < 6; i++) begin
            bus.aluValid = vecs[i].v;
            bus.aluNum   = vecs[i].num;
            bus.aluData  = vecs[i].data;
            if (vecs[i].exp_we) expect_wr(vecs[i].exp_num, vecs[i].exp_data);
            tick();
            chk($sformatf("alu%0d_regWrite", i), 32'(bus.regWrite), 32'(vecs[i].exp_we));
            chk($sformatf("alu%0d_wrNum", i), 32'(bus.wrNum), 32'(vecs[i].exp_num));
            chk($sformatf("alu%0d_wrData", i), bus.wrData, vecs[i].exp_data);
        end
        bus.aluValid = 0;

        // Long result with idle ALU
        bus.issueLng = 1; bus.issueNum = 5'd5;
        tick();
        bus.issueLng = 0;
        chk("lng_pend_set", bus.pendMask, 32'h20);
        bus.lngValid = 1; bus.lngNum = 5'd5; bus.lngData = 32'h1234;
        chk("lng_ready", 32'(bus.lngReady), 32'd1);
        expect_wr(5'd5, 32'h1234);
        tick();
        bus.lngValid = 0;
        chk("lng_k1_regWrite", 32'(bus.regWrite), 32'd0);
        chk("lng_k1_pend", bus.pendMask, 32'h20);
        tick();
        chk("lng_k2_regWrite", 32'(bus.regWrite), 32'd1);
        chk("lng_k2_pend", bus.pendMask, 32'h0);
        tick();

        // Contention: two long results while the ALU is busy for 4 cycles
        bus.aluValid = 1; bus.aluNum = 5'd10; bus.aluData = 32'hA0;
        bus.lngValid = 1; bus.lngNum = 5'd2; bus.lngData = 32'd7;
        expect_wr(5'd10, 32'hA0);
        tick();
        bus.aluNum = 5'd11; bus.aluData = 32'hA1;
        bus.lngNum = 5'd4; bus.lngData = 32'd9;
        chk("cont_ready_one", 32'(bus.lngReady), 32'd1);
        expect_wr(5'd11, 32'hA1);
        tick();
        chk("cont_stall_full", 32'(bus.stallReq), 32'd1);
        chk("cont_ready_full", 32'(bus.lngReady), 32'd0);
        bus.aluNum = 5'd12; bus.aluData = 32'hA2;
        bus.lngNum = 5'd7; bus.lngData = 32'h77;
        expect_wr(5'd12, 32'hA2);
        tick();
        bus.lngValid = 0;
        chk("cont_stall_hold", 32'(bus.stallReq), 32'd1);
        bus.aluNum = 5'd13; bus.aluData = 32'hA3;
        expect_wr(5'd13, 32'hA3);
        tick();
        bus.aluValid = 0;
        expect_wr(5'd2, 32'd7);
        expect_wr(5'd4, 32'd9);
        chk("cont_stall_after_alu", 32'(bus.stallReq), 32'd1);
        tick();
        chk("cont_stall_drop", 32'(bus.stallReq), 32'd0);
        chk("cont_ready_back", 32'(bus.lngReady), 32'd1);
        chk("cont_first_num", 32'(bus.wrNum), 32'd2);
        tick();
        chk("cont_second_num", 32'(bus.wrNum), 32'd4);
        chk("cont_second_data", bus.wrData, 32'd9);
        tick();
        chk("cont_idle_regWrite", 32'(bus.regWrite), 32'd0);

        // Same-edge set and clear of r6
        bus.issueLng = 1; bus.issueNum = 5'd6;
        tick();
        bus.issueLng = 0;
        bus.lngValid = 1; bus.lngNum = 5'd6; bus.lngData = 32'hAA;
        expect_wr(5'd6, 32'hAA);
        tick();
        bus.lngValid = 0;
        bus.issueLng = 1; bus.issueNum = 5'd6;
        tick();
        bus.issueLng = 0;
        chk("same_edge_pend", bus.pendMask, 32'h40);
        bus.lngValid = 1; bus.lngNum = 5'd6; bus.lngData = 32'hBB;
        expect_wr(5'd6, 32'hBB);
        tick();
        bus.lngValid = 0;
        tick();
        chk("second_pop_pend", bus.pendMask, 32'h0);
        chk("second_pop_data", bus.wrData, 32'hBB);

        // Reset mid-operation with two buffered results
        bus.issueLng = 1; bus.issueNum = 5'd4;
        tick();
        bus.issueNum = 5'd5;
        tick();
        bus.issueLng = 0;
        bus.aluValid = 1; bus.aluNum = 5'd0; bus.aluData = 32'hF0;
        bus.lngValid = 1; bus.lngNum = 5'd4; bus.lngData = 32'd1;
        tick();
        bus.lngNum = 5'd5; bus.lngData = 32'd2;
        tick();
        bus.lngValid = 0;
        chk("mid_stall", 32'(bus.stallReq), 32'd1);
        chk("mid_pend", bus.pendMask, 32'h30);
        rst = 1'b0;
        bus.aluValid = 0;
        tick();
        chk("mid_rst_regWrite", 32'(bus.regWrite), 32'd0);
        chk("mid_rst_pend", bus.pendMask, 32'h0);
        chk("mid_rst_ready", 32'(bus.lngReady), 32'd0);
        chk("mid_rst_stall", 32'(bus.stallReq), 32'd0);
        rst = 1'b1;
        #1;
        chk("post_rst_ready", 32'(bus.lngReady), 32'd1);
        tick();
        chk("post_rst_regWrite0", 32'(bus.regWrite), 32'd0);
        tick();
        chk("post_rst_regWrite1", 32'(bus.regWrite), 32'd0);
        bus.aluValid = 1; bus.aluNum = 5'd9; bus.aluData = 32'h900D;
        expect_wr(5'd9, 32'h900D);
        tick();
        bus.aluValid = 0;
        chk("post_rst_alu", 32'(bus.wrNum), 32'd9);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
        tick();
        chk("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
